cache_victim_ctrl: RTL and testbench
====================================

Name: cache_victim_ctrl

Overview:
Miss-handling controller that sits directly upstream of the per-set LRU block in the cache subsystem.
- On a cache miss, presents the set index to the LRU block and selects a victim way (an invalid way first, otherwise the LRU way).
- Sequences an optional dirty writeback and then a line refill.
- Feeds the chosen way back to the LRU block as an access update, so the refilled way becomes MRU.

Parameters:
WAYS, 4, associativity; power of two, >=2
INDEX_BITS, 8, set index width
TAG_BITS, 20, tag width
WAY_BITS, log2(WAYS), derived; encoded way width

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
miss_valid  in  1  miss request present
miss_ready  out  1  controller idle, accepts miss
miss_index  in  INDEX_BITS  set index of missing line
miss_tag  in  TAG_BITS  tag of missing line
way_valid  in  WAYS  valid bits of the set addressed by current_index
way_dirty  in  WAYS  dirty bits of that set
way_tags  in  WAYS*TAG_BITS  tags of that set; way w at [w*TAG_BITS +: TAG_BITS]
lru  in  WAYS  one-hot LRU way from LRU block
current_index  out  INDEX_BITS  set index driven to LRU block and tag/state arrays
wb_valid  out  1  writeback request
wb_ready  in  1  writeback accepted
wb_way  out  WAY_BITS  victim way
wb_tag  out  TAG_BITS  victim tag
fill_valid  out  1  refill request
fill_ready  in  1  refill accepted
fill_way  out  WAY_BITS  way to refill
fill_tag  out  TAG_BITS  = latched miss_tag
fill_done  in  1  refill data written, single-cycle pulse
access  out  WAY_BITS  way reported to LRU block
access_valid  out  1  LRU update strobe, one cycle
done  out  1  miss complete, one-cycle pulse

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; every output and all latched registers are 0, including miss_ready. miss_ready rises on the first clock edge after reset deasserts.
- FSM states: IDLE, SELECT, WB_REQ, FILL_REQ, FILL_WAIT, UPDATE. All outputs are registered or derived only from state and latched registers.
- IDLE:
  - miss_ready=1.
  - On miss_valid&&miss_ready: latch index and tag; current_index<=miss_index; go to SELECT.
  - The accept cycle is the only cycle in which a miss is taken. miss_ready=0 in every other state.
- SELECT (exactly 1 cycle; lets the LRU block and arrays present the set):
  - If any way_valid bit is 0, victim = lowest-numbered invalid way.
  - Otherwise victim = encode(lru).
  - If lru has multiple bits set, victim = lowest set bit. If lru is zero, victim = way 0.
  - Latch the victim and its tag.
  - Go to WB_REQ if the victim is valid and dirty; otherwise go to FILL_REQ.
- WB_REQ:
  - wb_valid=1; wb_way and wb_tag stay stable until wb_ready is sampled high.
  - Then go to FILL_REQ. wb_valid drops the following cycle.
- FILL_REQ: fill_valid=1 with fill_way, fill_tag and current_index stable until fill_ready; then go to FILL_WAIT.
- FILL_WAIT:
  - Wait for fill_done, then go to UPDATE.
  - fill_done in any other state is ignored.
- UPDATE (1 cycle): access=victim, access_valid=1, done=1; next state IDLE. access holds its value after the strobe.
- current_index holds the latched index from acceptance until the next accepted miss.
- Latency, clean miss with fill_ready=1 in FILL_REQ and fill_done on the first FILL_WAIT cycle: accept T0, SELECT T1, FILL_REQ T2, FILL_WAIT T3, access_valid/done at T4, miss_ready=1 at T5.
- A dirty victim adds at least 1 cycle (the WB_REQ handshake).
- Reset mid-operation: the transaction is abandoned. wb_valid, fill_valid and access_valid drop immediately; no LRU update is issued.
- wb_tag and fill_tag are pure pass-through of latched values; no arithmetic.

Decomposition:
- Package cache_repl_pkg:
  - FSM state enumeration (3-bit encoding).
  - log2 function.
  - Fixed-priority one-hot-to-binary helper function.
- One natural sub-module: victim_select. It is combinational; it takes way_valid, way_dirty, lru and way_tags, and produces victim way, victim tag and needs_wb.
- The FSM and latches stay in cache_victim_ctrl.

Test Plan:
1. Reset: hold reset low 5 cycles -> all outputs 0, miss_ready=0; release reset -> miss_ready=1 one edge later.
2. Invalid way preferred: miss_index=1, way_valid=4'b1011, lru=4'b1000, fill_ready=1, fill_done 1 cycle later -> no wb_valid; fill_way=2; access=2 with access_valid high exactly 1 cycle; current_index=1 throughout.
3. Clean LRU victim: way_valid=4'hF, way_dirty=0, lru=4'b1000 -> fill_way=3, access=3, done asserted 4 cycles after accept.
4. Dirty victim with backpressure: way_valid=4'hF, way_dirty=4'b0001, lru=4'b0001, tag0=20'h12345, wb_ready low 3 cycles -> wb_valid held with wb_way=0, wb_tag=20'h12345; fill_valid stays low until the cycle after the wb handshake; access=0.
5. Busy and illegal LRU: miss_valid held high during FILL_WAIT -> miss_ready=0, second miss taken only after done. lru=4'b0000 with all ways valid -> victim way 0.
6. Reset mid-FILL_WAIT: assert reset -> fill_valid and access_valid are 0 immediately; no access_valid after release; next miss is processed normally.

Source files
------------

// File: rtl/cache_repl_pkg.sv
// Shared types and helpers for the cache replacement path: the miss FSM state
// encoding, a constant log2, and a fixed-priority vector-to-index encoder.
package cache_repl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_WB_REQ    = 3'd2,
        ST_FILL_REQ  = 3'd3,
        ST_FILL_WAIT = 3'd4,
        ST_UPDATE    = 3'd5
    } state_t;

    // Widest way vector the encoder accepts; callers zero-extend into it.
    localparam int MAX_WAYS = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Lowest set bit wins, so a corrupt multi-hot vector still resolves
    // deterministically; an all-zero vector encodes to 0.
    function automatic int unsigned onehot_lsb_to_bin(input logic [MAX_WAYS-1:0] vec);
        int unsigned result;
        result = 0;
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (vec[i]) result = i;
        end
        return result;
    endfunction

endpackage

// File: rtl/cache_victim_ctrl_if.sv
// Bundle between the miss controller and its environment (miss source, LRU
// block, tag/state arrays, writeback and refill engines).
interface cache_victim_ctrl_if
    import cache_repl_pkg::*;
#(
    parameter int WAYS       = 4,
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 20,
    parameter int WAY_BITS   = clog2(WAYS)
);

    logic                     miss_valid;
    logic                     miss_ready;
    logic [INDEX_BITS-1:0]    miss_index;
    logic [TAG_BITS-1:0]      miss_tag;

    logic [WAYS-1:0]          way_valid;
    logic [WAYS-1:0]          way_dirty;
    logic [WAYS*TAG_BITS-1:0] way_tags;
    logic [WAYS-1:0]          lru;
    logic [INDEX_BITS-1:0]    current_index;

    logic                     wb_valid;
    logic                     wb_ready;
    logic [WAY_BITS-1:0]      wb_way;
    logic [TAG_BITS-1:0]      wb_tag;

    logic                     fill_valid;
    logic                     fill_ready;
    logic [WAY_BITS-1:0]      fill_way;
    logic [TAG_BITS-1:0]      fill_tag;
    logic                     fill_done;

    logic [WAY_BITS-1:0]      access;
    logic                     access_valid;
    logic                     done;

    // Controller side.
    modport master (
        input  miss_valid, miss_index, miss_tag,
        input  way_valid, way_dirty, way_tags, lru,
        input  wb_ready, fill_ready, fill_done,
        output miss_ready, current_index,
        output wb_valid, wb_way, wb_tag,
        output fill_valid, fill_way, fill_tag,
        output access, access_valid, done
    );

    // Environment side.
    modport slave (
        output miss_valid, miss_index, miss_tag,
        output way_valid, way_dirty, way_tags, lru,
        output wb_ready, fill_ready, fill_done,
        input  miss_ready, current_index,
        input  wb_valid, wb_way, wb_tag,
        input  fill_valid, fill_way, fill_tag,
        input  access, access_valid, done
    );

endinterface

// File: rtl/cache_victim_ctrl_victim_select.sv
// Combinational victim choice for one set: lowest invalid way first, otherwise
// the LRU way; reports the victim's tag and whether it must be written back.
module victim_select
    import cache_repl_pkg::*;
#(
    parameter int WAYS     = 4,
    parameter int TAG_BITS = 20,
    parameter int WAY_BITS = clog2(WAYS)
) (
    input  logic [WAYS-1:0]          way_valid,
    input  logic [WAYS-1:0]          way_dirty,
    input  logic [WAYS-1:0]          lru,
    input  logic [WAYS*TAG_BITS-1:0] way_tags,
    output logic [WAY_BITS-1:0]      victim_way,
    output logic [TAG_BITS-1:0]      victim_tag,
    output logic                     needs_wb
);

    logic [MAX_WAYS-1:0] invalid_ext;
    logic [MAX_WAYS-1:0] lru_ext;

    always_comb begin
        invalid_ext            = '0;
        lru_ext                = '0;
        invalid_ext[WAYS-1:0]  = ~way_valid;
        lru_ext[WAYS-1:0]      = lru;

        // Filling an empty way never evicts live data, so it beats the LRU hint.
        if (|invalid_ext) begin
            victim_way = WAY_BITS'(onehot_lsb_to_bin(invalid_ext));
        end else begin
            victim_way = WAY_BITS'(onehot_lsb_to_bin(lru_ext));
        end

        victim_tag = way_tags[int'(victim_way) * TAG_BITS +: TAG_BITS];
        needs_wb   = way_valid[victim_way] & way_dirty[victim_way];
    end

endmodule

// File: rtl/cache_victim_ctrl.sv
// Miss-handling controller: picks a victim way for the missing set, sequences
// an optional dirty writeback and a refill, then marks the refilled way MRU.
module cache_victim_ctrl
    import cache_repl_pkg::*;
#(
    parameter int WAYS       = 4,
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 20,
    parameter int WAY_BITS   = clog2(WAYS)
) (
    input  logic                clock,
    input  logic                reset,
    cache_victim_ctrl_if.master bus
);

    state_t                state;
    state_t                next_state;

    logic                  miss_ready_q;
    logic [INDEX_BITS-1:0] index_q;
    logic [TAG_BITS-1:0]   tag_q;
    logic [WAY_BITS-1:0]   victim_way_q;
    logic [TAG_BITS-1:0]   victim_tag_q;
    logic [WAY_BITS-1:0]   access_q;

    logic [WAY_BITS-1:0]   sel_way;
    logic [TAG_BITS-1:0]   sel_tag;
    logic                  sel_wb;
    logic                  accept;

    victim_select #(
        .WAYS     (WAYS),
        .TAG_BITS (TAG_BITS),
        .WAY_BITS (WAY_BITS)
    ) u_victim_select (
        .way_valid  (bus.way_valid),
        .way_dirty  (bus.way_dirty),
        .lru        (bus.lru),
        .way_tags   (bus.way_tags),
        .victim_way (sel_way),
        .victim_tag (sel_tag),
        .needs_wb   (sel_wb)
    );

    assign accept = (state == ST_IDLE) && bus.miss_valid && miss_ready_q;

    always_comb begin
        // NOTE: next_state takes a default before the case so every path assigns it and no latch is inferred.
        next_state = state;
        case (state)
            ST_IDLE:      if (accept)         next_state = ST_SELECT;
            ST_SELECT:    next_state = sel_wb ? ST_WB_REQ : ST_FILL_REQ;
            ST_WB_REQ:    if (bus.wb_ready)   next_state = ST_FILL_REQ;
            ST_FILL_REQ:  if (bus.fill_ready) next_state = ST_FILL_WAIT;
            ST_FILL_WAIT: if (bus.fill_done)  next_state = ST_UPDATE;
            ST_UPDATE:    next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    // miss_ready is a register rather than a decode of ST_IDLE so that it reads
    // 0 while reset is held and rises only on the first edge after release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            miss_ready_q <= 1'b0;
            index_q      <= '0;
            tag_q        <= '0;
            victim_way_q <= '0;
            victim_tag_q <= '0;
            access_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            state        <= next_state;
            miss_ready_q <= (next_state == ST_IDLE);

            if (accept) begin
                index_q <= bus.miss_index;
                tag_q   <= bus.miss_tag;
            end

            if (state == ST_SELECT) begin
                victim_way_q <= sel_way;
                victim_tag_q <= sel_tag;
            end

            if ((state == ST_FILL_WAIT) && bus.fill_done) begin
                access_q <= victim_way_q;
            end
        end
    end

    // Strobes decode from state alone, so an async reset drops them at once.
    assign bus.miss_ready    = miss_ready_q;
    assign bus.current_index = index_q;

    assign bus.wb_valid      = (state == ST_WB_REQ);
    assign bus.wb_way        = victim_way_q;
    assign bus.wb_tag        = victim_tag_q;

    assign bus.fill_valid    = (state == ST_FILL_REQ);
    assign bus.fill_way      = victim_way_q;
    assign bus.fill_tag      = tag_q;

    assign bus.access        = access_q;
    assign bus.access_valid  = (state == ST_UPDATE);
    assign bus.done          = (state == ST_UPDATE);

endmodule

// File: tb/tb_cache_victim_ctrl.sv
// Directed bench for cache_victim_ctrl: reset, victim choice, writeback
// backpressure, busy behaviour, illegal LRU and reset during a refill.
module tb_cache_victim_ctrl;
    import cache_repl_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    cache_victim_ctrl_if #(.WAYS(4), .INDEX_BITS(8), .TAG_BITS(20), .WAY_BITS(2)) bus ();

    cache_victim_ctrl #(.WAYS(4), .INDEX_BITS(8), .TAG_BITS(20), .WAY_BITS(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_miss(input logic [7:0] idx, input logic [19:0] tag);
        bus.miss_valid = 1'b1;
        bus.miss_index = idx;
        bus.miss_tag   = tag;
        tick();
        bus.miss_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) tick();
        checks++;
        if ({bus.miss_ready, bus.wb_valid, bus.fill_valid, bus.access_valid, bus.done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=00000",
                     {bus.miss_ready, bus.wb_valid, bus.fill_valid, bus.access_valid, bus.done});
        end
        checks++;
        if ({bus.current_index, bus.wb_way, bus.wb_tag, bus.fill_way, bus.fill_tag, bus.access} !== '0) begin
            failures++;
            $display("FAIL reset_regs idx=%h wb_way=%h wb_tag=%h fill_way=%h fill_tag=%h access=%h exp=all zero",
                     bus.current_index, bus.wb_way, bus.wb_tag, bus.fill_way, bus.fill_tag, bus.access);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.miss_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_early got=%b exp=0", bus.miss_ready);
        end
        tick();
        checks++;
        if (bus.miss_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=1", bus.miss_ready);
        end
    endtask

    task automatic test_invalid_way();
        bus.way_valid  = 4'b1011;
        bus.way_dirty  = 4'b1111;
        bus.lru        = 4'b1000;
        bus.fill_ready = 1'b1;
        bus.fill_done  = 1'b0;
        start_miss(8'd1, 20'hAAAAA);
        // SELECT
        checks++;
        if ({bus.current_index, bus.miss_ready, bus.wb_valid} !== {8'd1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL inv_select idx=%0d ready=%b wb_valid=%b exp=1/0/0",
                     bus.current_index, bus.miss_ready, bus.wb_valid);
        end
        tick();  // FILL_REQ
        checks++;
        if ({bus.fill_valid, bus.fill_way, bus.fill_tag, bus.wb_valid, bus.current_index} !==
            {1'b1, 2'd2, 20'hAAAAA, 1'b0, 8'd1}) begin
            failures++;
            $display("FAIL inv_fill_req fv=%b way=%0d tag=%h wb=%b idx=%0d exp=1/2/aaaaa/0/1",
                     bus.fill_valid, bus.fill_way, bus.fill_tag, bus.wb_valid, bus.current_index);
        end
        tick();  // FILL_WAIT
        checks++;
        if ({bus.fill_valid, bus.access_valid, bus.wb_valid} !== 3'b000) begin
            failures++;
            $display("FAIL inv_fill_wait fv=%b av=%b wb=%b exp=000",
                     bus.fill_valid, bus.access_valid, bus.wb_valid);
        end
        bus.fill_done = 1'b1;
        tick();  // UPDATE
        bus.fill_done = 1'b0;
        checks++;
        if ({bus.access_valid, bus.done, bus.access, bus.current_index} !== {1'b1, 1'b1, 2'd2, 8'd1}) begin
            failures++;
            $display("FAIL inv_update av=%b done=%b access=%0d idx=%0d exp=1/1/2/1",
                     bus.access_valid, bus.done, bus.access, bus.current_index);
        end
        tick();  // IDLE
        checks++;
        if ({bus.access_valid, bus.done, bus.access, bus.miss_ready, bus.current_index} !==
            {1'b0, 1'b0, 2'd2, 1'b1, 8'd1}) begin
            failures++;
            $display("FAIL inv_after av=%b done=%b access=%0d ready=%b idx=%0d exp=0/0/2/1/1",
                     bus.access_valid, bus.done, bus.access, bus.miss_ready, bus.current_index);
        end
    endtask

    task automatic test_clean_lru();
        int          cyc;
        logic        seen_wb;
        logic [1:0]  seen_fill_way;
        bus.way_valid  = 4'hF;
        bus.way_dirty  = 4'h0;
        bus.lru        = 4'b1000;
        bus.fill_ready = 1'b1;
        seen_wb        = 1'b0;
        seen_fill_way  = 2'd0;
        start_miss(8'h22, 20'h0C1EA);
        bus.fill_done = 1'b1;  // ignored until FILL_WAIT
        cyc = 1;
        while (!bus.done && cyc < 12) begin
            if (bus.wb_valid) seen_wb = 1'b1;
            if (bus.fill_valid) seen_fill_way = bus.fill_way;
            tick();
            cyc++;
        end
        bus.fill_done = 1'b0;
        checks++;
        if (cyc !== 4) begin
            failures++;
            $display("FAIL clean_latency got=%0d exp=4", cyc);
        end
        checks++;
        if ({seen_wb, seen_fill_way, bus.access, bus.access_valid} !== {1'b0, 2'd3, 2'd3, 1'b1}) begin
            failures++;
            $display("FAIL clean_victim wb=%b fill_way=%0d access=%0d av=%b exp=0/3/3/1",
                     seen_wb, seen_fill_way, bus.access, bus.access_valid);
        end
        tick();
    endtask

    task automatic test_dirty_wb();
        bus.way_valid  = 4'hF;
        bus.way_dirty  = 4'b0001;
        bus.lru        = 4'b0001;
        bus.way_tags   = {20'h33333, 20'h22222, 20'h11111, 20'h12345};
        bus.wb_ready   = 1'b0;
        bus.fill_ready = 1'b1;
        bus.fill_done  = 1'b0;
        start_miss(8'h40, 20'h0BEEF);
        tick();  // WB_REQ
        bus.way_tags = {20'h33333, 20'h22222, 20'h11111, 20'h54321};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.wb_valid, bus.wb_way, bus.wb_tag, bus.fill_valid} !== {1'b1, 2'd0, 20'h12345, 1'b0}) begin
                failures++;
                $display("FAIL dirty_wb_hold[%0d] wv=%b way=%0d tag=%h fv=%b exp=1/0/12345/0",
                         i, bus.wb_valid, bus.wb_way, bus.wb_tag, bus.fill_valid);
            end
            if (i < 2) tick();
        end
        bus.wb_ready = 1'b1;
        tick();  // FILL_REQ
        bus.wb_ready = 1'b0;
        checks++;
        if ({bus.wb_valid, bus.fill_valid, bus.fill_way, bus.fill_tag, bus.current_index} !==
            {1'b0, 1'b1, 2'd0, 20'h0BEEF, 8'h40}) begin
            failures++;
            $display("FAIL dirty_fill wv=%b fv=%b way=%0d tag=%h idx=%h exp=0/1/0/0beef/40",
                     bus.wb_valid, bus.fill_valid, bus.fill_way, bus.fill_tag, bus.current_index);
        end
        tick();  // FILL_WAIT
        bus.fill_done = 1'b1;
        tick();  // UPDATE
        bus.fill_done = 1'b0;
        checks++;
        if ({bus.access_valid, bus.done, bus.access} !== {1'b1, 1'b1, 2'd0}) begin
            failures++;
            $display("FAIL dirty_update av=%b done=%b access=%0d exp=1/1/0",
                     bus.access_valid, bus.done, bus.access);
        end
        tick();
    endtask

    task automatic test_busy_illegal_lru();
        bus.way_valid  = 4'hF;
        bus.way_dirty  = 4'h0;
        bus.lru        = 4'b0000;
        bus.fill_ready = 1'b1;
        bus.fill_done  = 1'b0;
        bus.miss_valid = 1'b1;
        bus.miss_index = 8'd5;
        bus.miss_tag   = 20'h55555;
        tick();  // accepted, SELECT
        bus.miss_index = 8'd6;
        bus.miss_tag   = 20'h66666;
        checks++;
        if (bus.miss_ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_select_ready got=%b exp=0", bus.miss_ready);
        end
        tick();  // FILL_REQ
        bus.lru = 4'b0110;
        checks++;
        if ({bus.fill_valid, bus.fill_way, bus.fill_tag, bus.miss_ready} !== {1'b1, 2'd0, 20'h55555, 1'b0}) begin
            failures++;
            $display("FAIL zero_lru_fill fv=%b way=%0d tag=%h ready=%b exp=1/0/55555/0",
                     bus.fill_valid, bus.fill_way, bus.fill_tag, bus.miss_ready);
        end
        tick();  // FILL_WAIT, stalled
        tick();
        tick();
        checks++;
        if ({bus.miss_ready, bus.current_index, bus.done} !== {1'b0, 8'd5, 1'b0}) begin
            failures++;
            $display("FAIL busy_wait ready=%b idx=%0d done=%b exp=0/5/0",
                     bus.miss_ready, bus.current_index, bus.done);
        end
        bus.fill_done = 1'b1;
        tick();  // UPDATE
        bus.fill_done = 1'b0;
        checks++;
        if ({bus.done, bus.access, bus.miss_ready, bus.current_index} !== {1'b1, 2'd0, 1'b0, 8'd5}) begin
            failures++;
            $display("FAIL busy_update done=%b access=%0d ready=%b idx=%0d exp=1/0/0/5",
                     bus.done, bus.access, bus.miss_ready, bus.current_index);
        end
        tick();  // IDLE, pending miss visible
        checks++;
        if ({bus.miss_ready, bus.current_index} !== {1'b1, 8'd5}) begin
            failures++;
            $display("FAIL busy_idle ready=%b idx=%0d exp=1/5", bus.miss_ready, bus.current_index);
        end
        tick();  // second miss accepted, SELECT
        bus.miss_valid = 1'b0;
        checks++;
        if ({bus.miss_ready, bus.current_index} !== {1'b0, 8'd6}) begin
            failures++;
            $display("FAIL second_accept ready=%b idx=%0d exp=0/6", bus.miss_ready, bus.current_index);
        end
        tick();  // FILL_REQ
        checks++;
        if ({bus.fill_valid, bus.fill_way, bus.fill_tag} !== {1'b1, 2'd1, 20'h66666}) begin
            failures++;
            $display("FAIL multi_lru_fill fv=%b way=%0d tag=%h exp=1/1/66666",
                     bus.fill_valid, bus.fill_way, bus.fill_tag);
        end
        tick();  // FILL_WAIT
        bus.fill_done = 1'b1;
        tick();  // UPDATE
        bus.fill_done = 1'b0;
        checks++;
        if ({bus.access_valid, bus.access} !== {1'b1, 2'd1}) begin
            failures++;
            $display("FAIL multi_lru_update av=%b access=%0d exp=1/1", bus.access_valid, bus.access);
        end
        tick();
    endtask

    task automatic test_reset_mid_fill();
        int   cyc;
        logic seen_av;
        bus.way_valid  = 4'hF;
        bus.way_dirty  = 4'h0;
        bus.lru        = 4'b0010;
        bus.fill_ready = 1'b1;
        bus.fill_done  = 1'b0;
        start_miss(8'd9, 20'h99999);
        tick();  // FILL_REQ
        tick();  // FILL_WAIT
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.fill_valid, bus.access_valid, bus.wb_valid, bus.done, bus.miss_ready} !== 5'b0) begin
            failures++;
            $display("FAIL midreset_strobes fv=%b av=%b wv=%b done=%b ready=%b exp=00000",
                     bus.fill_valid, bus.access_valid, bus.wb_valid, bus.done, bus.miss_ready);
        end
        checks++;
        if ({bus.current_index, bus.access} !== {8'd0, 2'd0}) begin
            failures++;
            $display("FAIL midreset_regs idx=%0d access=%0d exp=0/0", bus.current_index, bus.access);
        end
        bus.fill_done = 1'b1;
        tick();
        tick();
        reset   = 1'b1;
        seen_av = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.access_valid) seen_av = 1'b1;
        end
        checks++;
        if ({seen_av, bus.miss_ready} !== 2'b01) begin
            failures++;
            $display("FAIL midreset_after seen_av=%b ready=%b exp=0/1", seen_av, bus.miss_ready);
        end
        bus.fill_done = 1'b0;
        bus.lru       = 4'b0100;
        start_miss(8'h77, 20'h77777);
        bus.fill_done = 1'b1;
        cyc = 1;
        while (!bus.done && cyc < 12) begin
            tick();
            cyc++;
        end
        bus.fill_done = 1'b0;
        checks++;
        if ({cyc[3:0], bus.access, bus.current_index, bus.access_valid} !== {4'd4, 2'd2, 8'h77, 1'b1}) begin
            failures++;
            $display("FAIL midreset_next cyc=%0d access=%0d idx=%h av=%b exp=4/2/77/1",
                     cyc, bus.access, bus.current_index, bus.access_valid);
        end
        tick();
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b0;
        bus.miss_valid = 1'b0;
        bus.miss_index = '0;
        bus.miss_tag   = '0;
        bus.way_valid  = '0;
        bus.way_dirty  = '0;
        bus.way_tags   = {20'h33333, 20'h22222, 20'h11111, 20'h00A0A};
        bus.lru        = '0;
        bus.wb_ready   = 1'b0;
        bus.fill_ready = 1'b0;
        bus.fill_done  = 1'b0;

        test_reset();
        test_invalid_way();
        test_clean_lru();
        test_dirty_wb();
        test_busy_illegal_lru();
        test_reset_mid_fill();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
